// File: rtl/iter_shifter_pkg.sv
// iter_shifter_pkg
// Shared definitions for the iterative shifter and anything that models it:
//   - operation encoding (identical to the single-cycle barrel shifter)
//   - controller state encoding
//   - default operand width
package iter_shifter_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CNT_W = 4;

    // Operation encoding: bit 1 selects direction (0 = left, 1 = right),
    // bit 0 selects fill (0 = rotate, 1 = logical shift with zero fill).
    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRL = 2'b11;

    // 2'b11 is unused; the controller treats it as a return to idle.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

endpackage

// File: rtl/iter_shifter_shift_step.sv
// shift_step
// Purely combinational single-position mover used by the iterative shifter.
// Ports:
//   data_i  WIDTH  current working value
//   op_i    2      operation (OP_ROL / OP_SLL / OP_ROR / OP_SRL)
//   data_o  WIDTH  value moved exactly one bit position
module shift_step
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [1:0]       op_i,
    output logic [WIDTH-1:0] data_o
);

    always_comb begin
        data_o = data_i;
        case (op_i)
            OP_ROL:  data_o = {data_i[WIDTH-2:0], data_i[WIDTH-1]};
            OP_SLL:  data_o = {data_i[WIDTH-2:0], 1'b0};
            OP_ROR:  data_o = {data_i[0], data_i[WIDTH-1:1]};
            OP_SRL:  data_o = {1'b0, data_i[WIDTH-1:1]};
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/iter_shifter.sv
// iter_shifter
// Multi-cycle rotate/shift unit: moves the operand one bit per clock, so a
// request with count Cnt produces its result Cnt+1 cycles after acceptance.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only when idle)
//   In, Cnt, Op         operand, amount (0..WIDTH-1), operation
//   out_valid/out_ready result handshake
//   Out                 working/result register (holds last result when idle)
//   busy                high while shifting
module iter_shifter
    import iter_shifter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] In,
    input  logic [CNT_W-1:0] Cnt,
    input  logic [1:0]       Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] data_q,  data_d;
    logic [CNT_W-1:0] rem_q,   rem_d;
    logic [1:0]       op_q,    op_d;
    logic [WIDTH-1:0] step_data;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .data_i (data_q),
        .op_i   (op_q),
        .data_o (step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rem_q   <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        rem_d     = rem_q;
        op_d      = op_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = In;
                    rem_d   = Cnt;
                    op_d    = Op;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                // The cycle that sees rem==0 only hands off to DONE, which is
                // what makes the latency Cnt+1 rather than Cnt.
                if (rem_q != '0) begin
                    data_d = step_data;
                    rem_d  = rem_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                out_valid = 1'b1;
                // in_ready is low here, so a new request can only be taken
                // on the cycle after the result handshake.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign Out = data_q;

endmodule

// File: tb/tb_iter_shifter.sv
module tb_iter_shifter;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] In;
    logic [3:0]  Cnt;
    logic [1:0]  Op;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] Out;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    iter_shifter #(
        .WIDTH (16),
        .CNT_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .In        (In),
        .Cnt       (Cnt),
        .Op        (Op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Out       (Out),
        .busy      (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference barrel shifter built from whole-word shifts.
    function automatic logic [15:0] barrel(input logic [15:0] d, input int c, input logic [1:0] op);
        logic [31:0] dd;
        logic [15:0] r;
        r = d;
        case (op)
            2'b00: begin dd = {d, d} << c; r = dd[31:16]; end
            2'b01: r = d << c;
            2'b10: begin dd = {d, d} >> c; r = dd[15:0]; end
            2'b11: r = d >> c;
            default: r = d;
        endcase
        return r;
    endfunction

    task automatic run_req(input logic [15:0] din, input logic [3:0] c, input logic [1:0] op,
                           input logic [15:0] exp, input int stall, input bit noise);
        int waitc;
        int cyc;
        int busy_n;
        logic [15:0] held;
        logic [15:0] expv;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check_val("in_ready_wait", {31'd0, in_ready}, 32'd1);
        In = din; Cnt = c; Op = op; in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;                     // accept edge (edge 0)
        if (noise) begin
            In  = 16'h1234;
            Cnt = 4'($urandom_range(0, 15));
            Op  = 2'($urandom_range(0, 3));
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        busy_n = 0;
        while (!out_valid && cyc < 40) begin
            if (busy) busy_n++;
            @(posedge clk); #1;
            cyc++;
        end
        check_val("latency", cyc, int'(c) + 1);
        check_val("busy_cycles", busy_n, int'(c) + 1);
        expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check_val("result", {16'd0, Out}, {16'd0, expv});
        held = Out;
        for (int i = 0; i < stall; i++) begin
            if (noise) begin
                in_valid = ~in_valid;
                In = 16'h1234;
            end
            @(posedge clk); #1;
            check_val("stall_valid", {31'd0, out_valid}, 32'd1);
            check_val("stall_out", {16'd0, Out}, {16'd0, held});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("post_hs_out_hold", {16'd0, Out}, {16'd0, held});
        $display("txn op=%0d in=0x%04h cnt=%0d out=0x%04h exp=0x%04h lat=%0d stall=%0d",
                 op, din, c, held, expv, cyc, stall);
    endtask

    initial begin
        logic [15:0] rd;
        logic [3:0]  rc;
        logic [1:0]  ro;
        rst = 1'b1; in_valid = 1'b0; In = '0; Cnt = '0; Op = '0; out_ready = 1'b0;
        #2;
        check_val("rst_out", {16'd0, Out}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        run_req(16'h8001, 4'd1,  2'b00, 16'h0003, 0, 1'b0);
        run_req(16'h00FF, 4'd4,  2'b01, 16'h0FF0, 0, 1'b0);
        run_req(16'h0001, 4'd15, 2'b10, 16'h0002, 0, 1'b0);
        run_req(16'h8000, 4'd0,  2'b11, 16'h8000, 0, 1'b0);
        run_req(16'hF0F0, 4'd4,  2'b11, 16'h0F0F, 3, 1'b1);

        // Abort a request mid-shift with an asynchronous reset.
        In = 16'hAAAA; Cnt = 4'd8; Op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_val("pre_abort_busy", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_val("abort_out", {16'd0, Out}, 32'd0);
        check_val("abort_out_valid", {31'd0, out_valid}, 32'd0);
        check_val("abort_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run_req(16'h1234, 4'd4, 2'b00, 16'h2341, 0, 1'b0);

        for (int n = 0; n < 1000; n++) begin
            rd = 16'($urandom);
            rc = 4'($urandom_range(0, 15));
            ro = 2'($urandom_range(0, 3));
            run_req(rd, rc, ro, barrel(rd, int'(rc), ro),
                    $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        check_val("queue_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iter_shifter.md
Name: iter_shifter

Overview:
Multi-cycle, area-lean counterpart to the single-cycle 16-bit barrel shifter. It performs the same four operations (rotate/shift, left/right) by moving the operand one bit position per clock. Requests arrive on a valid/ready input handshake; results leave on a valid/ready output handshake. It sits beside the ALU for low-power or low-area build variants and takes the same In/Cnt/Op encoding.

Parameters:
WIDTH, 16, operand and result width in bits.
CNT_W, 4, shift-count width; must equal log2(WIDTH).

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  request present on In/Cnt/Op
in_ready  output  1  block can accept a request; high only in IDLE
In  input  WIDTH  operand
Cnt  input  CNT_W  shift/rotate amount, 0..WIDTH-1
Op  input  2  00 rotate left, 01 shift left logical, 10 rotate right, 11 shift right logical
out_valid  output  1  Out holds a finished result
out_ready  input  1  consumer accepts the result
Out  output  WIDTH  working/result register
busy  output  1  high in SHIFT state

Behaviour:
- Reset (async, rst=1): state=IDLE, data=0, rem=0, op_q=0. Outputs: Out=0, in_ready=1, out_valid=0, busy=0.
- States: IDLE, SHIFT, DONE. Encoding is 2 bits; the unused code returns to IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid: data<=In, rem<=Cnt, op_q<=Op, go to SHIFT.
  - Otherwise hold. Out keeps the last result.
- SHIFT:
  - busy=1, in_ready=0.
  - If rem!=0: data<=step(data,op_q), rem<=rem-1, stay in SHIFT.
  - If rem==0: go to DONE.
- step() moves data exactly one position:
  - ROL: {d[W-2:0], d[W-1]}
  - SLL: {d[W-2:0], 0}
  - ROR: {d[0], d[W-1:1]}
  - SRL: {0, d[W-1:1]}
- DONE:
  - out_valid=1; Out is stable while out_valid=1 and out_ready=0.
  - On out_ready: go to IDLE. in_ready rises the following cycle.
  - No same-cycle re-accept.
- Latency: the accept edge is edge 0. out_valid is first high after edge Cnt+1.
  - Cnt=0 gives 1 cycle.
  - Cnt=15 gives 16 cycles.
- Throughput: one request outstanding at a time.
- in_valid, In, Cnt and Op are ignored while in_ready=0. Changing them mid-operation does not affect the result, because op and count are captured.
- Results must equal the barrel shifter for all In/Cnt/Op.
- Reset mid-operation: immediate return to reset values. No out_valid is produced for the aborted request.
- The Op encoding matches the barrel shifter bit-for-bit.

Decomposition:
- Shared package holds:
  - OP_ROL=2'b00, OP_SLL=2'b01, OP_ROR=2'b10, OP_SRL=2'b11
  - state constants ST_IDLE, ST_SHIFT, ST_DONE
  - WIDTH default
- One combinational sub-module, shift_step (data, op -> next data, single-position move). It is instantiated once inside iter_shifter and is reusable by the ALU bench model.

Test Plan:
- ROL In=0x8001 Cnt=1 -> out_valid after 2 cycles, Out=0x0003.
- SLL In=0x00FF Cnt=4 -> Out=0x0FF0 after 5 cycles; busy high for exactly 5 cycles.
- ROR In=0x0001 Cnt=15 -> Out=0x0002 after 16 cycles; SRL In=0x8000 Cnt=0 -> Out=0x8000 after 1 cycle.
- Backpressure: SRL In=0xF0F0 Cnt=4 -> Out=0x0F0F; hold out_ready=0 for 3 cycles.
  - Required: Out and out_valid stable.
  - Required: in_valid pulses with In=0x1234 are ignored.
  - After out_ready: in_ready=1 on the next cycle.
- Reset mid-shift: ROL In=0xAAAA Cnt=8, assert rst at cycle 3.
  - Required: Out=0, out_valid=0, in_ready=1 immediately.
  - Next request ROL 0x1234 Cnt=4 -> 0x2341.
- Randomized: 1000 random In/Cnt/Op compared against the barrel shifter model with random out_ready stalls; zero mismatches, latency always Cnt+1.
